rv_divider_seq: RTL and testbench

Parametrised sequential integer divider for the RV32M/RV64M execute stage. It implements DIV, DIVU, REM and REMU with full RISC-V semantics, including divide-by-zero and signed overflow. A configurable number of quotient bits is retired per cycle. The block uses valid/ready handshakes on both sides, holds its result under back-pressure, and accepts a pipeline flush that kills an in-flight operation.

---
 rtl/rv_divider_seq.sv | 159 +++++++++++++++
 tb/tb_rv_divider_seq.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_divider_seq.sv
// Sequential RV32M/RV64M divider: DIV/DIVU/REM/REMU via restoring division,
// BPC quotient bits per cycle, valid/ready on both sides, flush kills any operation.
module rv_divider_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned BPC   = 1,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned N  = XLEN / BPC;
  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            op_rem;
  logic            neg_q;
  logic            neg_r;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] rem;

  logic            accept;
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic            overflow;
  logic [XLEN-1:0] a_mag_in;
  logic [XLEN-1:0] b_mag_in;
  logic [XLEN-1:0] special_res;

  // in_ready depends only on state, flush and reset
  assign in_ready = (state == IDLE) && !flush && !reset;
  assign accept   = in_valid && in_ready;

  // Operand decode at accept: magnitudes, signs and the two special cases
  always_comb begin
    is_signed   = ~in_op[0];
    a_neg       = is_signed & in_a[XLEN-1];
    b_neg       = is_signed & in_b[XLEN-1];
    a_mag_in    = a_neg ? (XLEN'(0) - in_a) : in_a;
    b_mag_in    = b_neg ? (XLEN'(0) - in_b) : in_b;
    div_zero    = (in_b == '0);
    overflow    = is_signed && (in_a == INT_MIN) && (in_b == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = in_op[1] ? in_a : '1;
    end else if (overflow) begin
      special_res = in_op[1] ? '0 : in_a;
    end
  end

  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;

  // BPC chained restoring steps plus sign fix-up of the resulting pair
  always_comb begin
    rem_nxt = rem;
    quo_nxt = quo;
    trial   = '0;
    for (int unsigned i = 0; i < BPC; i++) begin
      trial   = {rem_nxt, quo_nxt[XLEN-1]};
      quo_nxt = {quo_nxt[XLEN-2:0], 1'b0};
      if (trial >= {1'b0, b_mag}) begin
        trial      = trial - {1'b0, b_mag};
        quo_nxt[0] = 1'b1;
      end
      rem_nxt = trial[XLEN-1:0];
    end
    quo_fix = neg_q ? (XLEN'(0) - quo_nxt) : quo_nxt;
    rem_fix = neg_r ? (XLEN'(0) - rem_nxt) : rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      cnt        <= '0;
      op_rem     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      b_mag      <= '0;
      quo        <= '0;
      rem        <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_rem  <= in_op[1];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            out_tag <= in_tag;
            b_mag   <= b_mag_in;
            quo     <= a_mag_in;
            rem     <= '0;
            cnt     <= CW'(N);
            if (div_zero || overflow) begin
              out_result <= special_res;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            out_result <= op_rem ? rem_fix : quo_fix;
            out_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_divider_seq.sv
// Bench for rv_divider_seq: three builds (32/1, 32/4, 64/2) checked against
// an arithmetic reference model every cycle, plus literal directed cases.
module tb_rv_divider_seq;

  logic clk;
  int   cyc;
  int   n_cmp;
  int   n_bad;
  bit   chk_en;

  logic        reset[3];
  logic        flush[3];
  logic        in_valid[3];
  logic        out_ready[3];
  logic [1:0]  in_op[3];
  logic [63:0] in_a[3];
  logic [63:0] in_b[3];
  logic [4:0]  in_tag[3];

  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2;
  logic [31:0] res0, res1;
  logic [63:0] res2;
  logic [4:0]  tag0, tag1, tag2;

  logic        rdy_w[3];
  logic        vld_w[3];
  logic [63:0] res_w[3];
  logic [4:0]  tag_w[3];

  assign rdy_w[0] = rdy0;
  assign rdy_w[1] = rdy1;
  assign rdy_w[2] = rdy2;
  assign vld_w[0] = vld0;
  assign vld_w[1] = vld1;
  assign vld_w[2] = vld2;
  assign res_w[0] = {32'h0, res0};
  assign res_w[1] = {32'h0, res1};
  assign res_w[2] = res2;
  assign tag_w[0] = tag0;
  assign tag_w[1] = tag1;
  assign tag_w[2] = tag2;

  rv_divider_seq #(.XLEN(32), .BPC(1), .TAG_W(5)) u0 (
    .clk(clk), .reset(reset[0]), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(rdy0), .in_op(in_op[0]),
    .in_a(in_a[0][31:0]), .in_b(in_b[0][31:0]), .in_tag(in_tag[0]),
    .out_valid(vld0), .out_ready(out_ready[0]), .out_result(res0), .out_tag(tag0));

  rv_divider_seq #(.XLEN(32), .BPC(4), .TAG_W(5)) u1 (
    .clk(clk), .reset(reset[1]), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(rdy1), .in_op(in_op[1]),
    .in_a(in_a[1][31:0]), .in_b(in_b[1][31:0]), .in_tag(in_tag[1]),
    .out_valid(vld1), .out_ready(out_ready[1]), .out_result(res1), .out_tag(tag1));

  rv_divider_seq #(.XLEN(64), .BPC(2), .TAG_W(5)) u2 (
    .clk(clk), .reset(reset[2]), .flush(flush[2]),
    .in_valid(in_valid[2]), .in_ready(rdy2), .in_op(in_op[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .in_tag(in_tag[2]),
    .out_valid(vld2), .out_ready(out_ready[2]), .out_result(res2), .out_tag(tag2));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int xl_of(input int d);
    return (d == 2) ? 64 : 32;
  endfunction

  function automatic int bp_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 4 : 2);
  endfunction

  function automatic logic [63:0] mask_of(input int xl);
    return (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic bit is_special(input int xl, input logic [1:0] op,
                                    input logic [63:0] a, input logic [63:0] b);
    logic [63:0] m, mn;
    m  = mask_of(xl);
    mn = 64'h1;
    mn = mn << (xl - 1);
    return ((b & m) == 64'h0) || (!op[0] && (a & m) == mn && (b & m) == m);
  endfunction

  // RISC-V division semantics from plain language-level arithmetic
  function automatic logic [63:0] ref_div(input int xl, input logic [1:0] op,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [31:0] ua, ub;
    int          sa, sb;
    logic [63:0] la, lb;
    longint      sla, slb;
    logic [63:0] r;
    r = 64'h0;
    if (xl == 32) begin
      ua = a[31:0];
      ub = b[31:0];
      sa = $signed(ua);
      sb = $signed(ub);
      if (ub == 32'h0)
        r = op[1] ? {32'h0, ua} : 64'hFFFF_FFFF;
      else if (!op[0] && ua == 32'h8000_0000 && ub == 32'hFFFF_FFFF)
        r = op[1] ? 64'h0 : {32'h0, ua};
      else begin
        case (op)
          2'd0:    r = {32'h0, 32'(sa / sb)};
          2'd1:    r = {32'h0, ua / ub};
          2'd2:    r = {32'h0, 32'(sa % sb)};
          default: r = {32'h0, ua % ub};
        endcase
      end
    end else begin
      la  = a;
      lb  = b;
      sla = $signed(la);
      slb = $signed(lb);
      if (lb == 64'h0)
        r = op[1] ? la : 64'hFFFF_FFFF_FFFF_FFFF;
      else if (!op[0] && la == 64'h8000_0000_0000_0000 && lb == 64'hFFFF_FFFF_FFFF_FFFF)
        r = op[1] ? 64'h0 : la;
      else begin
        case (op)
          2'd0:    r = 64'(sla / slb);
          2'd1:    r = la / lb;
          2'd2:    r = 64'(sla % slb);
          default: r = la % lb;
        endcase
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  bit          pend[3];
  int          due[3];
  logic [63:0] exp_res[3];
  logic [4:0]  exp_tag[3];

  // Reference model and per-cycle compare of every unit's outputs
  task automatic model_loop();
    logic er, ev;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 3; i++) begin
          er = !pend[i] && !flush[i] && !reset[i];
          ev = pend[i] && (cyc >= due[i]);
          chk($sformatf("u%0d in_ready", i), 64'(rdy_w[i]), 64'(er));
          chk($sformatf("u%0d out_valid", i), 64'(vld_w[i]), 64'(ev));
          if (ev && vld_w[i]) begin
            chk($sformatf("u%0d out_result", i), res_w[i], exp_res[i]);
            chk($sformatf("u%0d out_tag", i), 64'(tag_w[i]), 64'(exp_tag[i]));
          end
          if (reset[i] || flush[i]) begin
            pend[i] = 1'b0;
          end else if (in_valid[i] && er) begin
            pend[i]    = 1'b1;
            due[i]     = cyc + (is_special(xl_of(i), in_op[i], in_a[i], in_b[i]) ?
                                1 : xl_of(i) / bp_of(i) + 1);
            exp_res[i] = ref_div(xl_of(i), in_op[i], in_a[i], in_b[i]);
            exp_tag[i] = in_tag[i];
          end else if (ev && out_ready[i]) begin
            pend[i] = 1'b0;
          end
        end
      end
    end
  endtask

  // Present a request until accepted; t is the cycle index of the accept cycle
  task automatic issue(input int d, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] tag,
                       output int t, output int waits);
    waits = 0;
    @(posedge clk); #1;
    in_valid[d] = 1'b1;
    in_op[d]    = op;
    in_a[d]     = a & mask_of(xl_of(d));
    in_b[d]     = b & mask_of(xl_of(d));
    in_tag[d]   = tag;
    @(negedge clk);
    while (!rdy_w[d] && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    if (!rdy_w[d]) chk($sformatf("u%0d accept timeout", d), 64'(waits), 64'(0));
    t = cyc;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    in_op[d]    = 2'($urandom);
    in_a[d]     = {$urandom, $urandom} & mask_of(xl_of(d));
    in_b[d]     = {$urandom, $urandom} & mask_of(xl_of(d));
  endtask

  task automatic wait_result(input int d, input int t, output int lat, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!vld_w[d] && n < 150) begin
      @(negedge clk);
      n++;
    end
    ok  = vld_w[d];
    lat = cyc - t;
    if (!ok) chk($sformatf("u%0d result timeout", d), 64'(ok), 64'(1));
  endtask

  task automatic run_op(input string name, input int d, input logic [1:0] op,
                        input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                        input logic [63:0] exp, input int exp_lat);
    int t, w, lat;
    bit ok;
    issue(d, op, a, b, tag, t, w);
    wait_result(d, t, lat, ok);
    if (ok) begin
      chk({name, " result"}, res_w[d], exp);
      chk({name, " tag"}, 64'(tag_w[d]), 64'(tag));
      chk({name, " latency"}, 64'(lat), 64'(exp_lat));
    end
  endtask

  function automatic logic [63:0] rnd_opnd(input int xl);
    logic [63:0] v;
    case ($urandom % 6)
      0:       v = 64'h0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: begin
        v = 64'h1;
        v = v << (xl - 1);
      end
      3:       v = 64'($urandom_range(1, 20));
      4:       v = 64'h0 - 64'($urandom_range(1, 20));
      default: v = {$urandom, $urandom};
    endcase
    return v & mask_of(xl);
  endfunction

  task automatic rand_phase(input int d, input int count);
    logic [63:0] a, b;
    logic [1:0]  op;
    int          t, w, lat;
    bit          ok;
    for (int k = 0; k < count; k++) begin
      @(posedge clk); #1;
      out_ready[d] = ($urandom % 3) != 0;
      op = 2'($urandom);
      a  = rnd_opnd(xl_of(d));
      b  = rnd_opnd(xl_of(d));
      issue(d, op, a, b, 5'($urandom), t, w);
      if ($urandom % 8 == 0) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1 flush[d] = 1'b1;
        @(posedge clk); #1;
        flush[d] = 1'b0;
        continue;
      end
      wait_result(d, t, lat, ok);
      if (!out_ready[d]) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1 out_ready[d] = 1'b1;
      end
    end
    @(posedge clk); #1;
    out_ready[d] = 1'b1;
    repeat (3) @(posedge clk);
  endtask

  // Kill an in-flight DIVU in its 10th CALC cycle with flush (kind 0) or reset (kind 1)
  task automatic kill_test(input int kind);
    int  t, w;
    bit  seen;
    issue(0, 2'd1, 64'd1000, 64'd3, 5'h0A, t, w);
    repeat (9) @(posedge clk);
    #1;
    if (kind == 0) flush[0] = 1'b1; else reset[0] = 1'b1;
    @(negedge clk);
    chk("kill in_ready low", 64'(rdy_w[0]), 64'(0));
    @(posedge clk); #1;
    flush[0] = 1'b0;
    reset[0] = 1'b0;
    @(negedge clk);
    chk("kill in_ready next", 64'(rdy_w[0]), 64'(1));
    chk("kill out_valid next", 64'(vld_w[0]), 64'(0));
    if (kind == 1) begin
      chk("reset out_result", res_w[0], 64'h0);
      chk("reset out_tag", 64'(tag_w[0]), 64'h0);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (vld_w[0]) seen = 1'b1;
    end
    chk("kill no result", 64'(seen), 64'(0));
    run_op("divu after kill", 0, 2'd1, 64'hFFFF_FFFF, 64'd3, 5'h0B, 64'h5555_5555, 33);
  endtask

  initial begin
    int  t, w, lat;
    bit  ok;
    n_cmp  = 0;
    n_bad  = 0;
    chk_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      reset[i] = 1'b1; flush[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b1;
      in_op[i] = 2'd0; in_a[i] = 64'h0; in_b[i] = 64'h0; in_tag[i] = 5'h0;
      pend[i] = 1'b0; due[i] = 0; exp_res[i] = 64'h0; exp_tag[i] = 5'h0;
    end
    fork
      model_loop();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d rst in_ready", i), 64'(rdy_w[i]), 64'(0));
      chk($sformatf("u%0d rst out_valid", i), 64'(vld_w[i]), 64'(0));
      chk($sformatf("u%0d rst out_result", i), res_w[i], 64'h0);
      chk($sformatf("u%0d rst out_tag", i), 64'(tag_w[i]), 64'h0);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) reset[i] = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("u%0d in_ready after rst", i), 64'(rdy_w[i]), 64'(1));

    // Directed literal cases on the 32-bit, 1 bit/cycle unit
    run_op("div -7/2",        0, 2'd0, 64'hFFFF_FFF9, 64'd2, 5'h01, 64'hFFFF_FFFD, 33);
    run_op("rem -7/2",        0, 2'd2, 64'hFFFF_FFF9, 64'd2, 5'h02, 64'hFFFF_FFFF, 33);
    run_op("divu 5/0",        0, 2'd1, 64'd5, 64'd0, 5'h03, 64'hFFFF_FFFF, 1);
    run_op("remu 5/0",        0, 2'd3, 64'd5, 64'd0, 5'h04, 64'd5, 1);
    run_op("div -9/0",        0, 2'd0, 64'hFFFF_FFF7, 64'd0, 5'h05, 64'hFFFF_FFFF, 1);
    run_op("rem -9/0",        0, 2'd2, 64'hFFFF_FFF7, 64'd0, 5'h06, 64'hFFFF_FFF7, 1);
    run_op("div ovf",         0, 2'd0, 64'h8000_0000, 64'hFFFF_FFFF, 5'h07, 64'h8000_0000, 1);
    run_op("rem ovf",         0, 2'd2, 64'h8000_0000, 64'hFFFF_FFFF, 5'h08, 64'h0, 1);
    run_op("divu ovf-pat",    0, 2'd1, 64'h8000_0000, 64'hFFFF_FFFF, 5'h09, 64'h0, 33);

    // Back-pressure: hold result for 10 stalled cycles, then back-to-back accept
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    issue(0, 2'd3, 64'd100, 64'd7, 5'h13, t, w);
    wait_result(0, t, lat, ok);
    chk("bp latency", 64'(lat), 64'(33));
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp out_result", res_w[0], 64'd2);
      chk("bp out_tag", 64'(tag_w[0]), 64'h13);
      chk("bp in_ready", 64'(rdy_w[0]), 64'(0));
      chk("bp out_valid", 64'(vld_w[0]), 64'(1));
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
    issue(0, 2'd0, 64'd100, 64'hFFFF_FFF9, 5'h14, t, w);
    chk("bp ready next cycle", 64'(w), 64'(0));
    wait_result(0, t, lat, ok);
    chk("bp div 100/-7", res_w[0], 64'hFFFF_FFF2);
    chk("bp div latency", 64'(lat), 64'(33));

    kill_test(0);
    kill_test(1);

    run_op("bpc4 remu 100/7", 1, 2'd3, 64'd100, 64'd7, 5'h15, 64'd2, 9);
    run_op("x64 div min/3",   2, 2'd0, 64'h8000_0000_0000_0000, 64'd3, 5'h16,
           64'hD555_5555_5555_5556, 33);
    run_op("x64 rem min/3",   2, 2'd2, 64'h8000_0000_0000_0000, 64'd3, 5'h17,
           64'hFFFF_FFFF_FFFF_FFFE, 33);

    for (int d = 0; d < 3; d++) rand_phase(d, 60);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
